// File: rtl/rtc_time_reader.sv
// Periodic DS1307-style RTC poller: drives the I2C master's request side, decodes the
// returned BCD seconds/minutes/hours into binary 24-hour time and counts failed polls.
module rtc_time_reader #(
    parameter int         ClockFrequency    = 1000000,
    parameter int         PollPeriodMs      = 500,
    parameter logic [6:0] DeviceAddress     = 7'h68,
    parameter int         MaxBytesToSend    = 16,
    parameter int         MaxBytesToRead    = 16,
    parameter int         BusyTimeoutCycles = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    output logic                              i2cStart,
    output logic [6:0]                        i2cAddress,
    output logic [$clog2(MaxBytesToSend):0]   i2cNrOfBytesToSend,
    output logic [MaxBytesToSend*8-1:0]       i2cBytesToSend,
    output logic [$clog2(MaxBytesToRead):0]   i2cNrOfBytesToRead,
    input  logic [MaxBytesToRead*8-1:0]       i2cBytesToRead,
    input  logic                              i2cReady,
    input  logic                              i2cClockStretchTimeoutReached,
    input  logic                              i2cNoAcknowledge,
    output logic [4:0]                        hours,
    output logic [5:0]                        minutes,
    output logic [5:0]                        seconds,
    output logic                              clockHalted,
    output logic                              timeValid,
    output logic                              timeUpdated,
    output logic                              busy,
    output logic [7:0]                        errorCount
);

    localparam longint unsigned PERIOD = longint'(PollPeriodMs) * longint'(ClockFrequency) / 1000;
    localparam int              CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(PERIOD - 1);
    localparam int              BUSY_W = $clog2(BusyTimeoutCycles + 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BusyTimeoutCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQUEST, ST_WAIT_BUSY, ST_WAIT_DONE, ST_CHECK, ST_UPDATE, ST_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              tick;
    logic              load_time;

    logic [4:0] hours_q;
    logic [5:0] minutes_q, seconds_q;
    logic       halted_q, valid_q;
    logic [7:0] err_q;

    logic [7:0] sec_b, min_b, hr_b;
    logic [6:0] sec_bin, min_bin;
    logic [5:0] h24, h12, hr_bin;
    logic       range_err;
    logic       unused_bytes;

    // Read request is a fixed "write pointer 0x00, read 3 bytes" transaction.
    assign i2cAddress         = DeviceAddress;
    assign i2cNrOfBytesToSend = ($clog2(MaxBytesToSend)+1)'(1);
    assign i2cBytesToSend     = '0;
    assign i2cNrOfBytesToRead = ($clog2(MaxBytesToRead)+1)'(3);

    assign sec_b = i2cBytesToRead[23:16];
    assign min_b = i2cBytesToRead[15:8];
    assign hr_b  = i2cBytesToRead[7:0];
    assign unused_bytes = ^{i2cBytesToRead[MaxBytesToRead*8-1:24], min_b[7], hr_b[7]};

    assign tick = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);

    always_comb begin
        sec_bin   = 7'(sec_b[6:4]) * 7'd10 + 7'(sec_b[3:0]);
        min_bin   = 7'(min_b[6:4]) * 7'd10 + 7'(min_b[3:0]);
        h24       = 6'(hr_b[5:4]) * 6'd10 + 6'(hr_b[3:0]);
        h12       = 6'(hr_b[4]) * 6'd10 + 6'(hr_b[3:0]);
        hr_bin    = h24;
        range_err = (sec_b[3:0] > 4'd9) || (min_b[3:0] > 4'd9) || (hr_b[3:0] > 4'd9)
                 || (sec_bin > 7'd59) || (min_bin > 7'd59);
        if (hr_b[6]) begin
            // 12-hour mode: bit 5 is PM, 12 AM is midnight and 12 PM is noon.
            if (h12 == 6'd0 || h12 > 6'd12) range_err = 1'b1;
            if (h12 == 6'd12)  hr_bin = hr_b[5] ? 6'd12 : 6'd0;
            else if (hr_b[5])  hr_bin = h12 + 6'd12;
            else               hr_bin = h12;
        end
        if (hr_bin > 6'd23) range_err = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = '0;
        case (state_q)
            ST_IDLE:      if (tick && enable) state_d = ST_REQUEST;
            ST_REQUEST:   state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!i2cReady)                     state_d = ST_WAIT_DONE;
                else if (busy_cnt_q == BUSY_LAST)  state_d = ST_FAIL;
                else                               busy_cnt_d = busy_cnt_q + BUSY_W'(1);
            end
            ST_WAIT_DONE: if (i2cReady) state_d = ST_CHECK;
            ST_CHECK: begin
                if (i2cNoAcknowledge || i2cClockStretchTimeoutReached || range_err)
                    state_d = ST_FAIL;
                else
                    state_d = ST_UPDATE;
            end
            ST_UPDATE:    state_d = ST_IDLE;
            ST_FAIL:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Time is captured on the Check->Update edge so it is visible while Update pulses.
    assign load_time = (state_q == ST_CHECK) && (state_d == ST_UPDATE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= TICK_LAST;
            busy_cnt_q <= '0;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            halted_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            if (load_time) begin
                hours_q   <= hr_bin[4:0];
                minutes_q <= min_bin[5:0];
                seconds_q <= sec_bin[5:0];
                halted_q  <= sec_b[7];
                valid_q   <= 1'b1;
            end
            if (state_q == ST_FAIL && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    assign i2cStart    = (state_q == ST_REQUEST);
    assign timeUpdated = (state_q == ST_UPDATE);
    assign busy        = (state_q != ST_IDLE);
    assign hours       = hours_q;
    assign minutes     = minutes_q;
    assign seconds     = seconds_q;
    assign clockHalted = halted_q;
    assign timeValid   = valid_q;
    assign errorCount  = err_q;

endmodule
